// File: rtl/processorci_bridge_pkg.sv
// Shared types and constants for the tinyriscv RIB to Controller memory bridge.
package processorci_bridge_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;

    localparam logic [DATA_W-1:0] DEFAULT_ERR_DATA = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } bridge_state_t;

endpackage

// File: rtl/bus_timeout_counter.sv
// Saturating BUSY-cycle counter; expired rises in the cycle the count reaches TIMEOUT_CYCLES-1.
module bus_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned LAST  = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    logic [CNT_W-1:0] cnt;
    logic             at_last_c;

    assign at_last_c = (cnt == CNT_W'(LAST));

    // Must be combinational so the abort lands on the same BUSY cycle the limit is reached.
    assign expired = (TIMEOUT_CYCLES != 0) && at_last_c;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (enable && !at_last_c) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/rib_mem_bridge.sv
// Adapts the single-cycle tinyriscv data bus to the held-request Controller memory port,
// stalling the core until ack or timeout and returning the read word for one cycle.
module rib_mem_bridge
    import processorci_bridge_pkg::*;
#(
    parameter int unsigned        TIMEOUT_CYCLES = 1024,
    parameter logic [DATA_W-1:0]  ERR_DATA       = DEFAULT_ERR_DATA
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_hold,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              bus_err
);

    bridge_state_t state;
    logic          capture_c;
    logic          expired;

    assign capture_c = (state == IDLE) && core_req;

    // Stall in the request cycle itself, before any register has seen the access.
    assign core_hold = capture_c || (state == BUSY);

    bus_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (capture_c),
        .enable (state == BUSY),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            core_rdata <= '0;
            bus_err    <= 1'b0;
        end else begin
            core_rdata <= '0;
            bus_err    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (core_req) begin
                        state     <= BUSY;
                        mem_addr  <= core_addr;
                        mem_wdata <= core_wdata;
                        mem_read  <= ~core_we;
                        mem_write <= core_we;
                    end
                end
                BUSY: begin
                    // Ack takes priority over a coincident timeout.
                    if (mem_ack) begin
                        state      <= DONE;
                        mem_read   <= 1'b0;
                        mem_write  <= 1'b0;
                        core_rdata <= mem_write ? '0 : mem_rdata;
                    end else if (expired) begin
                        state      <= DONE;
                        mem_read   <= 1'b0;
                        mem_write  <= 1'b0;
                        core_rdata <= ERR_DATA;
                        bus_err    <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rib_mem_bridge.sv
// Directed plus randomized checks of rib_mem_bridge against an access-timeline model.
module tb_rib_mem_bridge;

    localparam int          T_CYC = 8;
    localparam logic [31:0] ERR_W = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_req;
    logic        core_we;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic [31:0] core_rdata;
    logic        core_hold;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    rib_mem_bridge #(
        .TIMEOUT_CYCLES(T_CYC),
        .ERR_DATA      (ERR_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .core_req  (core_req),
        .core_we   (core_we),
        .core_addr (core_addr),
        .core_wdata(core_wdata),
        .core_rdata(core_rdata),
        .core_hold (core_hold),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_hold"},  32'(core_hold),  32'd0);
        check({tag, "_rd"},    32'(mem_read),   32'd0);
        check({tag, "_wr"},    32'(mem_write),  32'd0);
        check({tag, "_rdata"}, core_rdata,      32'd0);
        check({tag, "_err"},   32'(bus_err),    32'd0);
    endtask

    // One access: ack d cycles after BUSY entry (d >= T_CYC means it times out first).
    task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] word, input int d, input bit gap);
        bit          tmo;
        int          done_k;
        logic [31:0] exp_rd;
        bit          busy;
        tmo    = (d >= T_CYC);
        done_k = tmo ? T_CYC + 1 : d + 2;
        exp_rd = tmo ? ERR_W : (we ? 32'd0 : word);
        for (int k = 0; k <= done_k; k++) begin
            core_req = 1'b1;
            if (k == 0) begin
                core_we    = we;
                core_addr  = addr;
                core_wdata = wdata;
            end else begin
                core_we    = 1'($urandom);
                core_addr  = $urandom;
                core_wdata = $urandom;
            end
            mem_ack   = (k == d + 1);
            mem_rdata = (k == d + 1) ? word : $urandom;
            @(negedge clk);
            busy = (k >= 1) && (k < done_k);
            check("hold",  32'(core_hold), 32'(k < done_k));
            check("mem_read",  32'(mem_read),  32'(busy && !we));
            check("mem_write", 32'(mem_write), 32'(busy && we));
            if (k >= 1) begin
                check("mem_addr",  mem_addr,  addr);
                check("mem_wdata", mem_wdata, wdata);
            end
            check("core_rdata", core_rdata, (k == done_k) ? exp_rd : 32'd0);
            check("bus_err", 32'(bus_err), 32'((k == done_k) && tmo));
            @(posedge clk);
            #1;
        end
        mem_ack = 1'b0;
        if (gap) begin
            core_req = 1'b0;
            @(negedge clk);
            check_quiet("gap");
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset      = 1'b1;
        core_req   = 1'b0;
        core_we    = 1'b0;
        core_addr  = '0;
        core_wdata = '0;
        mem_rdata  = '0;
        mem_ack    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_quiet("reset");
        check("reset_addr",  mem_addr,  32'd0);
        check("reset_wdata", mem_wdata, 32'd0);
        @(posedge clk);
        #1;

        // Minimum-latency read.
        do_access(1'b0, 32'h100, 32'h0, 32'h12345678, 0, 1'b1);
        // Write with ack after 5 cycles while the core scrambles its bus.
        do_access(1'b1, 32'h200, 32'hA5A5A5A5, 32'h55AA55AA, 5, 1'b1);
        // Pure timeout, then ack on the expiry cycle.
        do_access(1'b0, 32'h300, 32'h0, 32'h0BADF00D, 1000, 1'b1);
        do_access(1'b0, 32'h304, 32'h0, 32'hC0FFEE00, T_CYC - 1, 1'b1);
        // Write timeout also returns the error word.
        do_access(1'b1, 32'h308, 32'h13579BDF, 32'h0, 1000, 1'b1);

        // Reset on BUSY cycle 3, then a stray ack in IDLE.
        core_req   = 1'b1;
        core_we    = 1'b0;
        core_addr  = 32'h400;
        core_wdata = 32'h0;
        @(posedge clk);
        #1;
        for (int k = 1; k <= 3; k++) begin
            core_addr = $urandom;
            if (k == 3) reset = 1'b1;
            @(posedge clk);
            #1;
        end
        reset    = 1'b0;
        core_req = 1'b0;
        @(negedge clk);
        check_quiet("abort");
        check("abort_addr",  mem_addr,  32'd0);
        check("abort_wdata", mem_wdata, 32'd0);
        @(posedge clk);
        #1;
        mem_ack   = 1'b1;
        mem_rdata = 32'hFEEDFACE;
        @(negedge clk);
        check_quiet("stray_ack");
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        @(negedge clk);
        check_quiet("after_stray");
        @(posedge clk);
        #1;
        do_access(1'b0, 32'h404, 32'h0, 32'h89ABCDEF, 3, 1'b1);

        // Back-to-back reads with core_req never dropping.
        do_access(1'b0, 32'h500, 32'h0, 32'h11111111, 0, 1'b0);
        do_access(1'b0, 32'h504, 32'h0, 32'h22222222, 0, 1'b0);
        do_access(1'b0, 32'h508, 32'h0, 32'h33333333, 2, 1'b1);

        // Random mix of reads, writes, latencies and timeouts.
        for (int n = 0; n < 40; n++) begin
            int d;
            d = ($urandom_range(0, 7) == 0) ? 1000 : int'($urandom_range(0, T_CYC));
            do_access(1'($urandom), $urandom, $urandom, $urandom, d, 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rib_mem_bridge.md
# rib_mem_bridge

Bridge between the tinyriscv execute-stage data bus (single-cycle, combinational-response expectation) and the Controller data-memory port (request held until acknowledged). It sits directly upstream of the Controller data port in `processorci_top`. It captures each core access, stalls the core through `rib_hold_flag_i` until memory acknowledges, and returns the read word for exactly one cycle. A programmable timeout converts a hung access into an error response.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1024: number of BUSY cycles before an access is aborted; 0 disables the timeout.
- `ERR_DATA`, default 32'hDEADBEEF: read data returned on timeout.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `core_req`  in  1  core data request (`rib_ex_req_o`).
- `core_we`  in  1  1 = write, 0 = read (`rib_ex_we_o`).
- `core_addr`  in  32  byte address.
- `core_wdata`  in  32  write word.
- `core_rdata`  out  32  read word to the core.
- `core_hold`  out  1  stall to the core (`rib_hold_flag_i`).
- `mem_read`  out  1  read request, level-held until ack.
- `mem_write`  out  1  write request, level-held until ack.
- `mem_addr`  out  32  captured address.
- `mem_wdata`  out  32  captured write word.
- `mem_rdata`  in  32  memory read word, valid while `mem_ack` = 1.
- `mem_ack`  in  1  one-cycle completion pulse.
- `bus_err`  out  1  one-cycle pulse on timeout.

## Operation
- FSM states: IDLE, BUSY, DONE.
- **IDLE**
  - On `core_req` = 1: capture `core_addr`, `core_wdata`, `core_we`, clear the timeout counter, and go to BUSY.
  - `mem_ack` is ignored in IDLE.
- **BUSY**
  - Drive `mem_read` = ~we or `mem_write` = we, never both.
  - On `mem_ack`: latch `mem_rdata` (writes latch 0) and go to DONE.
  - Otherwise, when `TIMEOUT_CYCLES` != 0 and the counter reaches `TIMEOUT_CYCLES`-1: latch `ERR_DATA`, pulse `bus_err` for one cycle, and go to DONE.
  - An ack and the timeout in the same cycle: the ack wins and `bus_err` stays 0.
- **DONE**
  - `core_hold` = 0 and `core_rdata` = the latched word.
  - Always go to IDLE. `core_req` is ignored in DONE because it belongs to the access just completed.
- **Output rules**
  - `core_hold` = (IDLE & `core_req`) | BUSY. This is combinational, so the core stalls in the same cycle it issues the request.
  - `core_rdata` = the latched word in DONE, otherwise 0.
- The captured address and data are stable for the whole of BUSY, even if the core's own outputs change.
- The counter saturates and does not wrap.

## Timing
- Reset (synchronous, 1 cycle): state IDLE, counter 0.
  - Outputs: `mem_read`/`mem_write`/`core_hold`/`bus_err` = 0; `core_rdata`/`mem_addr`/`mem_wdata` = 0.
  - Reset during BUSY abandons the access. A later `mem_ack` arrives in IDLE and is dropped.
- Minimum access is 3 cycles:
  - cycle 0: IDLE with req, hold = 1.
  - cycle 1: BUSY with ack, hold = 1.
  - cycle 2: DONE, hold = 0, rdata valid.
- An ack arriving N cycles after BUSY entry gives hold high for N+2 cycles.
- Back-to-back accesses: the next req is accepted in the IDLE cycle after DONE, so throughput is at most 1 access per 3 cycles.
- A timeout with `TIMEOUT_CYCLES` = T enters DONE T+1 cycles after the request cycle.
- `mem_addr`/`mem_wdata` hold their last captured values outside BUSY.

## Structure
- Package `processorci_bridge_pkg` holds:
  - the `bridge_state_t` enum (IDLE/BUSY/DONE);
  - the default `ERR_DATA` constant.
- Sub-module `bus_timeout_counter`:
  - parameter: `TIMEOUT_CYCLES`;
  - inputs: `clk`, `reset`, `clear`, `enable`;
  - output: `expired`, a saturating flag.
- The remaining FSM and capture registers sit in `rib_mem_bridge`.

## Test plan
- Read, ack in the first BUSY cycle: req read @0x100, `mem_rdata` = 0x12345678 -> `core_hold` high for 2 cycles, `core_rdata` = 0x12345678 for exactly 1 cycle, `mem_read` high for 1 cycle.
- Write, ack after 5 cycles: `core_wdata` = 0xA5A5A5A5 @0x200, core changes `core_addr`/`core_wdata` mid-hold -> `mem_write` held 6 cycles with `mem_addr`/`mem_wdata` unchanged at 0x200/0xA5A5A5A5; `core_rdata` = 0 in DONE.
- Timeout with `TIMEOUT_CYCLES` = 8 and no ack -> DONE 9 cycles after req, `core_rdata` = 0xDEADBEEF, single `bus_err` pulse. A variant with ack on the expiry cycle -> memory data returned and `bus_err` = 0.
- Reset asserted on BUSY cycle 3, then `mem_ack` pulsed after reset -> all outputs 0, state IDLE, stray ack ignored, and the next req proceeds normally.
- Back-to-back reads with `core_req` held continuously -> `core_req` ignored in DONE; a second capture in the following IDLE cycle; no duplicate memory request from the DONE cycle.
